// File: rtl/fifo_reader.sv
// fifo_reader: burst read engine between a first-word-fall-through FIFO and a valid/ready consumer.
// Optional: define FIFO_READER_STALL_CNT_EN to add the stall_cycles FIFO-underrun counter output.
module fifo_reader #(
    parameter int width = 16,
    parameter int len_w = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [len_w-1:0] burst_len,
    input  logic [width-1:0] fifo_dout,
    input  logic             fifo_pndng,
    output logic             fifo_pop,
    output logic [width-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
`ifdef FIFO_READER_STALL_CNT_EN
    output logic [31:0]      stall_cycles,
`endif
    output logic             done
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t           state, state_nxt;
    logic [len_w-1:0] remaining, remaining_nxt;
    logic             done_q, done_nxt;
    logic [1:0]       count;
    logic [width-1:0] head, skid;
    logic             accept;

    // Pop decision uses only registered state, so m_ready never reaches fifo_pop.
    assign fifo_pop = (state == READ) && fifo_pndng && (remaining != '0) && (count < 2'd2);
    assign accept   = m_valid && m_ready;
    assign m_valid  = (count != 2'd0);
    assign m_data   = head;
    assign busy     = (state != IDLE);
    assign done     = done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            remaining <= '0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            done_q    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        done_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (burst_len != '0) begin
                        state_nxt     = READ;
                        remaining_nxt = burst_len;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            READ: begin
                if (fifo_pop) begin
                    remaining_nxt = remaining - len_w'(1);
                    if (remaining == len_w'(1)) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if ((count == 2'd0) || ((count == 2'd1) && accept)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Two-entry buffer: head drives m_data, skid absorbs the word popped while head is stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 2'd0;
            head  <= '0;
            skid  <= '0;
        end else begin
            case ({fifo_pop, accept})
                2'b10: begin
                    if (count == 2'd0) head <= fifo_dout;
                    else               skid <= fifo_dout;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= skid;
                    count <= count - 2'd1;
                end
                2'b11: head <= fifo_dout;
                default: begin
                end
            endcase
        end
    end

`ifdef FIFO_READER_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if ((state == IDLE) && start) begin
            stall_cycles <= '0;
        end else if ((state == READ) && (remaining != '0) && !fifo_pndng &&
                     (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: randomized self-checking bench for fifo_reader with a queue-based FIFO and delivery model.
// Honours FIFO_READER_STALL_CNT_EN to also check the stall_cycles counter.
module tb_fifo_reader;

    localparam int W  = 16;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst, start, fifo_pndng, fifo_pop, m_valid, m_ready, busy, done;
    logic [LW-1:0] burst_len;
    logic [W-1:0]  fifo_dout, m_data;
`ifdef FIFO_READER_STALL_CNT_EN
    logic [31:0]   stall_cycles;
`endif

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [W-1:0]  fifo_q[$];
    logic [W-1:0]  got_q[$];
    int            pop_cyc[$];
    int            hs_cyc[$];
    int            done_cyc[$];
    int            busy_cnt, bad_pop, overlap, stable_viol;
    logic          prev_stall;
    logic [W-1:0]  prev_data;
    bit            rand_ready;

    always #5 clk = ~clk;

    fifo_reader #(.width(W), .len_w(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .burst_len(burst_len),
        .fifo_dout(fifo_dout), .fifo_pndng(fifo_pndng), .fifo_pop(fifo_pop),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy),
`ifdef FIFO_READER_STALL_CNT_EN
        .stall_cycles(stall_cycles),
`endif
        .done(done)
    );

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drive_fifo();
        fifo_pndng = (fifo_q.size() != 0);
        if (fifo_q.size() != 0) fifo_dout = fifo_q[0];
        else                    fifo_dout = '0;
    endtask

    task automatic clear_rec();
        got_q.delete();
        pop_cyc.delete();
        hs_cyc.delete();
        done_cyc.delete();
        busy_cnt    = 0;
        bad_pop     = 0;
        overlap     = 0;
        stable_viol = 0;
        prev_stall  = 1'b0;
    endtask

    // One clock cycle: observe at the falling edge, update the FIFO model just after the rising edge.
    task automatic cycle();
        logic         s_pop, s_hs;
        logic [W-1:0] tmp;
        @(negedge clk);
        s_pop = fifo_pop;
        s_hs  = m_valid && m_ready;
        if (s_pop && !fifo_pndng) bad_pop++;
        if (done && busy) overlap++;
        if (busy) busy_cnt++;
        if (done) done_cyc.push_back(cyc);
        if (prev_stall && (!m_valid || (m_data !== prev_data))) stable_viol++;
        prev_stall = rst && m_valid && !m_ready;
        prev_data  = m_data;
        if (s_hs) begin
            got_q.push_back(m_data);
            hs_cyc.push_back(cyc);
        end
        if (s_pop) pop_cyc.push_back(cyc);
        @(posedge clk);
        #1;
        if (s_pop && (fifo_q.size() != 0)) tmp = fifo_q.pop_front();
        start = 1'b0;
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
        drive_fifo();
        cyc++;
    endtask

    task automatic kick(input logic [LW-1:0] n);
        burst_len = n;
        start     = 1'b1;
        cycle();
    endtask

    task automatic run_until_done(input int bound, output bit timed_out);
        int n = 0;
        while ((done_cyc.size() == 0) && (n < bound)) begin
            cycle();
            n++;
        end
        timed_out = (done_cyc.size() == 0);
        cycle();
        cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; burst_len = '0; m_ready = 1'b0; rand_ready = 1'b0;
        fifo_q.delete();
        drive_fifo();
        #2 rst = 1'b0;
        #3;
        checks++;
        if ({fifo_pop, m_valid, busy, done} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: pop/valid/busy/done got %b expected 0000", {fifo_pop, m_valid, busy, done});
        end
        checks++;
        if (m_data !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: m_data got %h expected 0000", m_data);
        end
`ifdef FIFO_READER_STALL_CNT_EN
        checks++;
        if (stall_cycles !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_stall: stall_cycles got %0d expected 0", stall_cycles);
        end
`endif
        @(posedge clk); #1;
        rst = 1'b1;
        cycle();
        cycle();
        checks++;
        if (busy !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle: busy/valid got %b%b expected 00", busy, m_valid);
        end
    endtask

    task automatic test_basic_burst();
        int t0;
        bit to;
        clear_rec();
        rand_ready = 1'b0; m_ready = 1'b1;
        fifo_q = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
        drive_fifo();
        t0 = cyc;
        kick(8'd4);
        run_until_done(40, to);
        checks++;
        if (to) begin errors++; $display("[TB] FAIL basic_timeout: done got none expected a pulse"); end
        checks++;
        if (pop_cyc.size() != 4) begin
            errors++;
            $display("[TB] FAIL basic_popcnt: pops got %0d expected 4", pop_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (pop_cyc[i] != t0 + 1 + i) begin
                    errors++;
                    $display("[TB] FAIL basic_popcyc%0d: cycle got %0d expected %0d", i, pop_cyc[i] - t0, 1 + i);
                end
            end
        end
        checks++;
        if (got_q.size() != 4) begin
            errors++;
            $display("[TB] FAIL basic_wordcnt: words got %0d expected 4", got_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_q[i] !== 16'(16'hA001 + i) || hs_cyc[i] != t0 + 2 + i) begin
                    errors++;
                    $display("[TB] FAIL basic_word%0d: got %h@%0d expected %h@%0d", i, got_q[i], hs_cyc[i] - t0, 16'(16'hA001 + i), 2 + i);
                end
            end
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != t0 + 6) begin
            errors++;
            $display("[TB] FAIL basic_done: pulses got %0d expected 1 at cycle 6", done_cyc.size());
        end
        checks++;
        if (fifo_q.size() != 0 || fifo_pndng !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_end: fifo words %0d busy %b expected 0 and 0", fifo_q.size(), busy);
        end
    endtask

    task automatic test_partial_burst();
        logic [W-1:0] w[6];
        bit to;
        clear_rec();
        fifo_q.delete();
        for (int i = 0; i < 6; i++) begin
            w[i] = 16'($urandom);
            fifo_q.push_back(w[i]);
        end
        drive_fifo();
        rand_ready = 1'b1;
        kick(8'd3);
        run_until_done(200, to);
        checks++;
        if (to || pop_cyc.size() != 3 || got_q.size() != 3) begin
            errors++;
            $display("[TB] FAIL partial_counts: pops %0d words %0d expected 3 and 3", pop_cyc.size(), got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_q[i] !== w[i]) begin
                    errors++;
                    $display("[TB] FAIL partial_word%0d: got %h expected %h", i, got_q[i], w[i]);
                end
            end
            checks++;
            if (done_cyc.size() != 1 || done_cyc[0] != hs_cyc[2] + 1) begin
                errors++;
                $display("[TB] FAIL partial_done: pulses %0d expected 1 right after last handshake", done_cyc.size());
            end
        end
        checks++;
        if (fifo_q.size() != 3 || fifo_pndng !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL partial_left: fifo words %0d pndng %b busy %b expected 3 1 0", fifo_q.size(), fifo_pndng, busy);
        end else begin
            checks++;
            if (fifo_q[0] !== w[3] || fifo_q[2] !== w[5]) begin
                errors++;
                $display("[TB] FAIL partial_fifo: head %h expected %h", fifo_q[0], w[3]);
            end
        end
        rand_ready = 1'b0;
        fifo_q.delete();
        drive_fifo();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] w[5];
        bit to;
        clear_rec();
        fifo_q.delete();
        for (int i = 0; i < 5; i++) begin
            w[i] = 16'($urandom);
            fifo_q.push_back(w[i]);
        end
        drive_fifo();
        rand_ready = 1'b0; m_ready = 1'b0;
        kick(8'd5);
        repeat (10) cycle();
        checks++;
        if (pop_cyc.size() != 2 || fifo_pop !== 1'b0 || fifo_q.size() != 3) begin
            errors++;
            $display("[TB] FAIL bp_pops: pops %0d pop now %b expected 2 and 0", pop_cyc.size(), fifo_pop);
        end
        checks++;
        if (m_valid !== 1'b1 || m_data !== w[0] || stable_viol != 0) begin
            errors++;
            $display("[TB] FAIL bp_hold: valid %b data %h expected 1 %h stable", m_valid, m_data, w[0]);
        end
        m_ready = 1'b1;
        run_until_done(40, to);
        checks++;
        if (to || got_q.size() != 5 || done_cyc.size() != 1) begin
            errors++;
            $display("[TB] FAIL bp_finish: words %0d done %0d expected 5 and 1", got_q.size(), done_cyc.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got_q[i] !== w[i]) begin
                    errors++;
                    $display("[TB] FAIL bp_word%0d: got %h expected %h", i, got_q[i], w[i]);
                end
            end
        end
    endtask

    task automatic test_underrun();
        int t0;
        clear_rec();
        fifo_q.delete();
        drive_fifo();
        rand_ready = 1'b0; m_ready = 1'b1;
        t0 = cyc;
        kick(8'd2);
        for (int t = 1; (t < 80) && (done_cyc.size() == 0); t++) begin
            if (t == 20) fifo_q.push_back(16'h0BEE);
            if (t == 30) fifo_q.push_back(16'h0C0D);
            drive_fifo();
            cycle();
        end
        cycle();
        checks++;
        if (bad_pop != 0) begin
            errors++;
            $display("[TB] FAIL under_badpop: pops with empty FIFO got %0d expected 0", bad_pop);
        end
        checks++;
        if (pop_cyc.size() != 2 || pop_cyc[0] != t0 + 20 || pop_cyc[1] != t0 + 30) begin
            errors++;
            $display("[TB] FAIL under_popcyc: pops %0d expected 2 at cycles 20 and 30", pop_cyc.size());
        end
        checks++;
        if (got_q.size() != 2 || got_q[0] !== 16'h0BEE || got_q[1] !== 16'h0C0D) begin
            errors++;
            $display("[TB] FAIL under_words: count %0d expected 2 words 0bee 0c0d", got_q.size());
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != t0 + 32) begin
            errors++;
            $display("[TB] FAIL under_done: pulses %0d expected 1 at cycle 32", done_cyc.size());
        end
`ifdef FIFO_READER_STALL_CNT_EN
        checks++;
        if (stall_cycles !== 32'd28) begin
            errors++;
            $display("[TB] FAIL under_stall: stall_cycles got %0d expected 28", stall_cycles);
        end
`endif
    endtask

    task automatic test_zero_and_ignored_start();
        logic [W-1:0] w[5];
        int t0;
        bit to;
        clear_rec();
        fifo_q.delete();
        drive_fifo();
        rand_ready = 1'b0; m_ready = 1'b1;
        t0 = cyc;
        kick(8'd0);
        cycle();
        cycle();
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != t0 + 1 || pop_cyc.size() != 0 || busy_cnt != 0) begin
            errors++;
            $display("[TB] FAIL zero_len: done %0d pops %0d busy cycles %0d expected 1 0 0", done_cyc.size(), pop_cyc.size(), busy_cnt);
        end
        clear_rec();
        for (int i = 0; i < 5; i++) begin
            w[i] = 16'($urandom);
            fifo_q.push_back(w[i]);
        end
        drive_fifo();
        rand_ready = 1'b1;
        kick(8'd3);
        cycle();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ignored_pre: busy got %b expected 1", busy);
        end
        burst_len = 8'($urandom_range(1, 200));
        start = 1'b1;
        cycle();
        run_until_done(200, to);
        checks++;
        if (to || pop_cyc.size() != 3 || got_q.size() != 3 || fifo_q.size() != 2) begin
            errors++;
            $display("[TB] FAIL ignored_start: pops %0d words %0d left %0d expected 3 3 2", pop_cyc.size(), got_q.size(), fifo_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_q[i] !== w[i]) begin
                    errors++;
                    $display("[TB] FAIL ignored_word%0d: got %h expected %h", i, got_q[i], w[i]);
                end
            end
        end
        rand_ready = 1'b0;
        fifo_q.delete();
        drive_fifo();
    endtask

    task automatic test_reset_mid_burst();
        logic [W-1:0] w[4];
        bit to;
        clear_rec();
        fifo_q.delete();
        for (int i = 0; i < 4; i++) begin
            w[i] = 16'($urandom);
            fifo_q.push_back(w[i]);
        end
        drive_fifo();
        rand_ready = 1'b0; m_ready = 1'b0;
        kick(8'd4);
        repeat (3) cycle();
        checks++;
        if (m_valid !== 1'b1 || busy !== 1'b1 || fifo_q.size() != 2) begin
            errors++;
            $display("[TB] FAIL rstmid_pre: valid %b busy %b fifo %0d expected 1 1 2", m_valid, busy, fifo_q.size());
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({m_valid, fifo_pop, busy, done} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL rstmid_async: valid/pop/busy/done got %b expected 0000", {m_valid, fifo_pop, busy, done});
        end
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        checks++;
        if (busy !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_idle: busy %b valid %b expected 0 0", busy, m_valid);
        end
        clear_rec();
        m_ready = 1'b1;
        kick(8'd1);
        run_until_done(40, to);
        checks++;
        if (to || got_q.size() != 1 || fifo_q.size() != 1 || done_cyc.size() != 1) begin
            errors++;
            $display("[TB] FAIL rstmid_after: words %0d left %0d done %0d expected 1 1 1", got_q.size(), fifo_q.size(), done_cyc.size());
        end else begin
            checks++;
            if (got_q[0] !== w[2]) begin
                errors++;
                $display("[TB] FAIL rstmid_word: got %h expected %h", got_q[0], w[2]);
            end
        end
        fifo_q.delete();
        drive_fifo();
    endtask

    task automatic test_random_bursts();
        logic [W-1:0] w[$];
        int n, extra;
        bit to;
        for (int it = 0; it < 8; it++) begin
            clear_rec();
            n     = $urandom_range(1, 12);
            extra = $urandom_range(0, 3);
            w.delete();
            fifo_q.delete();
            for (int i = 0; i < n + extra; i++) begin
                w.push_back(16'($urandom));
                fifo_q.push_back(w[i]);
            end
            drive_fifo();
            rand_ready = 1'b1;
            kick(8'(n));
            run_until_done(n * 20 + 40, to);
            checks++;
            if (to || got_q.size() != n || fifo_q.size() != extra || done_cyc.size() != 1) begin
                errors++;
                $display("[TB] FAIL rand%0d_counts: words %0d left %0d done %0d expected %0d %0d 1", it, got_q.size(), fifo_q.size(), done_cyc.size(), n, extra);
            end else begin
                for (int i = 0; i < n; i++) begin
                    checks++;
                    if (got_q[i] !== w[i]) begin
                        errors++;
                        $display("[TB] FAIL rand%0d_word%0d: got %h expected %h", it, i, got_q[i], w[i]);
                    end
                end
            end
            checks++;
            if (bad_pop != 0 || overlap != 0 || stable_viol != 0) begin
                errors++;
                $display("[TB] FAIL rand%0d_rules: badpop %0d overlap %0d unstable %0d expected 0 0 0", it, bad_pop, overlap, stable_viol);
            end
        end
        rand_ready = 1'b0;
        fifo_q.delete();
        drive_fifo();
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_partial_burst();
        test_backpressure();
        test_underrun();
        test_zero_and_ignored_start();
        test_reset_mid_burst();
        test_random_bursts();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
